// File: rtl/aes256_pkg.sv
// Shared definitions for the AES-256 word-stream adapter: block width,
// core-control FSM states and the words-per-block helper.
package aes256_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT       = 2'd1,
    DRAIN_HOLD = 2'd2
  } core_state_t;

  // Number of stream words that make up one 128-bit block.
  function automatic int words_f(input int word_w);
    return BLOCK_W / word_w;
  endfunction

endpackage

// File: rtl/aes256_block_serializer.sv
// Output half of the AES-256 stream adapter: holds one result block and
// drains it as WORD_W-bit words, most significant word first, under a
// valid/ready handshake. Data and valid stay put while the sink stalls.
module aes256_block_serializer
  import aes256_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [BLOCK_W-1:0] load_data_i,
  output logic               full_o,
  output logic [WORD_W-1:0]  m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i
);

  localparam int WORDS = words_f(WORD_W);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [BLOCK_W-1:0] out_buf;
  logic [CNT_W-1:0]   out_cnt;
  logic               out_full;
  logic               fire;
  logic               last;

  assign fire = out_full && m_ready_i;
  assign last = (out_cnt == CNT_W'(WORDS - 1));

  // Load a finished block, then step through its words on each accepted handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_buf  <= '0;
      out_cnt  <= '0;
      out_full <= 1'b0;
    end else if (load_i) begin
      out_buf  <= load_data_i;
      out_cnt  <= '0;
      out_full <= 1'b1;
    end else if (fire) begin
      if (last) begin
        out_cnt  <= '0;
        out_full <= 1'b0;
      end else begin
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  // Present the current word; word 0 is the top slice of the block.
  always_comb begin
    m_data_o = out_buf[BLOCK_W - 1 - int'(out_cnt) * WORD_W -: WORD_W];
  end

  assign m_valid_o = out_full;
  assign full_o    = out_full;

endmodule

// File: rtl/aes256_stream_adapter.sv
// Word-serial front end for the AES-256 core. Packs WORD_W-bit words into
// 128-bit blocks, issues each block with a one-cycle start pulse, captures
// the result and hands it to the serializer. The input side refills while
// the core runs and the previous result drains.
// Optional feature macro: AES_CBC_EN (CBC chaining with IV load ports);
// without it the adapter runs ECB and the IV ports are absent.
module aes256_stream_adapter
  import aes256_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic               clk,
  input  logic               rst,
`ifdef AES_CBC_EN
  input  logic [BLOCK_W-1:0] iv_i,
  input  logic               iv_load_i,
`endif
  input  logic               mode_i,
  input  logic [WORD_W-1:0]  s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic [WORD_W-1:0]  m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic               core_start_o,
  output logic               core_mode_o,
  output logic [BLOCK_W-1:0] core_data_o,
  input  logic [BLOCK_W-1:0] core_data_i,
  input  logic               core_valid_i,
  input  logic               core_busy_i
);

  localparam int WORDS = words_f(WORD_W);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  core_state_t        state;
  logic [BLOCK_W-1:0] in_buf;
  logic [BLOCK_W-1:0] in_shift;
  logic [CNT_W-1:0]   in_cnt;
  logic               in_full;
  logic               out_full;
  logic               issue;
  logic               load;
  logic [BLOCK_W-1:0] issue_data;
  logic [BLOCK_W-1:0] result;
  logic [BLOCK_W-1:0] hold_buf;
  logic [BLOCK_W-1:0] load_data;

  assign s_ready_o = !in_full;
  assign issue     = (state == IDLE) && in_full && !out_full && !core_busy_i;
  assign load      = ((state == WAIT) && core_valid_i && !out_full) ||
                     ((state == DRAIN_HOLD) && !out_full);
  assign load_data = (state == DRAIN_HOLD) ? hold_buf : result;

  generate
    if (WORDS == 1) begin : g_one_word
      assign in_shift = s_data_i;
    end else begin : g_multi_word
      assign in_shift = {in_buf[BLOCK_W-WORD_W-1:0], s_data_i};
    end
  endgenerate

`ifdef AES_CBC_EN
  logic [BLOCK_W-1:0] chain;
  logic [BLOCK_W-1:0] chain_next;

  // Encrypt whitens the plaintext with the chain; decrypt sends ciphertext as-is.
  assign issue_data = mode_i ? in_buf : (in_buf ^ chain);
  // Decrypt unwhitens with the previous ciphertext, still in chain at capture.
  assign result     = core_mode_o ? (core_data_i ^ chain) : core_data_i;

  // Chain register: IV load between blocks, advance on every core result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain      <= '0;
      chain_next <= '0;
    end else begin
      if (issue) begin
        chain_next <= in_buf;
      end
      if ((state == WAIT) && core_valid_i) begin
        chain <= core_mode_o ? chain_next : core_data_i;
      end else if (iv_load_i && (state == IDLE) && (in_cnt == '0) && !in_full) begin
        chain <= iv_i;
      end
    end
  end
`else
  assign issue_data = in_buf;
  assign result     = core_data_i;
`endif

  // Input packer: shift words in, flag a full block, free it on issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_buf  <= '0;
      in_cnt  <= '0;
      in_full <= 1'b0;
    end else if (s_valid_i && !in_full) begin
      in_buf <= in_shift;
      if (in_cnt == CNT_W'(WORDS - 1)) begin
        in_cnt  <= '0;
        in_full <= 1'b1;
      end else begin
        in_cnt <= in_cnt + 1'b1;
      end
    end else if (issue) begin
      in_full <= 1'b0;
    end
  end

  // Core control FSM with registered start, mode and block outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      core_start_o <= 1'b0;
      core_mode_o  <= 1'b0;
      core_data_o  <= '0;
      hold_buf     <= '0;
    end else begin
      core_start_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue) begin
            core_data_o  <= issue_data;
            core_mode_o  <= mode_i;
            core_start_o <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (core_valid_i) begin
            if (out_full) begin
              hold_buf <= result;
              state    <= DRAIN_HOLD;
            end else begin
              state <= IDLE;
            end
          end
        end
        DRAIN_HOLD: begin
          if (!out_full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  aes256_block_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_data_i (load_data),
    .full_o      (out_full),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i)
  );

endmodule

// File: tb/tb_aes256_stream_adapter.sv
// Bench for aes256_stream_adapter (WORD_W = 32). The core is a stand-in
// with an 18-cycle latency: it returns the FIPS-197 AES-256 known-answer
// pair (key 000102..1f) for that plaintext/ciphertext and otherwise a
// simple invertible byte-rotate-and-xor mapping.
`timescale 1ns/1ps
module tb_aes256_stream_adapter;

  localparam int WORD_W = 32;
  localparam int LAT    = 18;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KMIX = 128'h000102030405060708090a0b0c0d0e0f;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [WORD_W-1:0]  s_data;
  logic               s_valid;
  logic               s_ready;
  logic [WORD_W-1:0]  m_data;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic               core_start;
  logic               core_mode;
  logic [127:0]       core_data_o;
  logic [127:0]       core_data_i;
  logic               core_valid;
  logic               core_busy;
`ifdef AES_CBC_EN
  logic [127:0]       iv;
  logic               iv_load;
`endif

  int tests = 0;
  int fails = 0;
  int starts = 0;
  logic [127:0] seen_data;
  logic         seen_mode;
  logic [31:0]  got[$];
  logic         toggle_en = 1'b0;
  logic         p_stall = 1'b0;
  logic [31:0]  p_data = '0;

  always #5 clk = ~clk;

  aes256_stream_adapter #(.WORD_W(WORD_W)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef AES_CBC_EN
    .iv_i         (iv),
    .iv_load_i    (iv_load),
`endif
    .mode_i       (mode),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .core_start_o (core_start),
    .core_mode_o  (core_mode),
    .core_data_o  (core_data_o),
    .core_data_i  (core_data_i),
    .core_valid_i (core_valid),
    .core_busy_i  (core_busy)
  );

  function automatic logic [127:0] enc_f(input logic [127:0] x);
    if (x == PT) return CT;
    return {x[119:0], x[127:120]} ^ KMIX;
  endfunction

  function automatic logic [127:0] dec_f(input logic [127:0] y);
    logic [127:0] t;
    if (y == CT) return PT;
    t = y ^ KMIX;
    return {t[7:0], t[127:8]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Core stand-in: latch on start, answer LAT cycles later with a valid pulse.
  int           ccnt;
  logic [127:0] cres;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_busy  <= 1'b0;
      core_valid <= 1'b0;
      ccnt       <= 0;
      cres       <= '0;
    end else begin
      core_valid <= 1'b0;
      if (core_start && !core_busy) begin
        core_busy <= 1'b1;
        ccnt      <= LAT - 1;
        cres      <= core_mode ? dec_f(core_data_o) : enc_f(core_data_o);
      end else if (core_busy) begin
        if (ccnt == 0) begin
          core_busy  <= 1'b0;
          core_valid <= 1'b1;
        end else begin
          ccnt <= ccnt - 1;
        end
      end
    end
  end
  assign core_data_i = cres;

  // Sink ready: always ready, or alternating when toggle_en is set.
  always @(posedge clk) begin
    #1;
    if (toggle_en) m_ready = ~m_ready;
    else           m_ready = 1'b1;
  end

  // Mid-cycle monitor: start pulses, output words, stall stability.
  always @(negedge clk) begin
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (core_start) begin
        starts++;
        seen_data = core_data_o;
        seen_mode = core_mode;
        check("start_while_out_full", m_valid, 0);
      end
      if (p_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, p_data);
      end
      if (m_valid && m_ready) got.push_back(m_data);
      p_stall = m_valid && !m_ready;
      p_data  = m_data;
    end
  end

  task automatic send_word(input logic [31:0] w);
    logic rdy;
    int   n;
    n = 0;
    s_data  = w;
    s_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 300);
    if (!rdy) check("send_word_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input logic md);
    mode = md;
    for (int i = 0; i < 4; i++) send_word(blk[127 - 32*i -: 32]);
  endtask

  task automatic wait_words(input int n);
    int c;
    c = 0;
    while (got.size() < n && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("wait_words", 128'(got.size()), 128'(n));
  endtask

  task automatic expect_block(input string name, input logic [127:0] exp);
    logic [31:0] w;
    wait_words(4);
    for (int i = 0; i < 4; i++) begin
      w = (got.size() > 0) ? got.pop_front() : 32'hx;
      check(name, w, exp[127 - 32*i -: 32]);
    end
  endtask

  task automatic wait_start(input int s0, input string name);
    int c;
    c = 0;
    while (starts <= s0 && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(name, (starts > s0), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_mode"}, core_mode, 0);
    check({tag, "_core_data"}, core_data_o, 0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
  endtask

  typedef struct {
    logic         md;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    vecs[0] = '{1'b0, PT, CT};
    vecs[1] = '{1'b1, CT, PT};
    vecs[2] = '{1'b0, 128'h0, KMIX};
    vecs[3] = '{1'b1, 128'h0, 128'h0f000102030405060708090a0b0c0d0e};
    vecs[4] = '{1'b0, 128'h11111111222222223333333344444444,
                      128'h11101321262724343b3a394f48494a1e};
    vecs[5] = '{1'b1, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0,
                      128'hffffffffffffffffffffffffffffffff};

    rst = 1'b1; mode = 1'b0; s_data = '0; s_valid = 1'b0;
`ifdef AES_CBC_EN
    iv = '0; iv_load = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Start pulse lands exactly one cycle after the last word's edge.
    s0 = starts;
    send_block(PT, 1'b0);
    check("full_blocks_ready", s_ready, 0);
    check("start_before_e1", core_start, 0);
    @(posedge clk);
    #1;
    check("start_after_e1", core_start, 1);
    check("issue_core_data", core_data_o, PT);
    @(posedge clk);
    #1;
    check("start_one_cycle", core_start, 0);
    expect_block("first_block", CT);
    check("first_start_count", 128'(starts - s0), 1);

`ifdef AES_CBC_EN
    // IV = PT, zero plaintext -> core sees PT, returns CT.
    @(posedge clk); #1;
    iv = PT; iv_load = 1'b1;
    @(posedge clk); #1;
    iv_load = 1'b0;
    send_block(128'h0, 1'b0);
    wait_start(starts - 1, "cbc_enc1_start");
    check("cbc_enc1_core_data", seen_data, PT);
    expect_block("cbc_enc1_out", CT);
    // Second block P2 = CT whitens to zero; C2 = enc(0) = KMIX.
    send_block(CT, 1'b0);
    expect_block("cbc_enc2_out", KMIX);
    check("cbc_enc2_core_data", seen_data, 128'h0);
    // Decrypt C2 with C1 as IV; an IV load during WAIT must be ignored.
    @(posedge clk); #1;
    iv = CT; iv_load = 1'b1;
    @(posedge clk); #1;
    iv_load = 1'b0;
    s0 = starts;
    send_block(KMIX, 1'b1);
    wait_start(s0, "cbc_dec_start");
    iv = '1; iv_load = 1'b1;
    @(posedge clk); #1;
    iv_load = 1'b0;
    check("cbc_dec_core_data", seen_data, KMIX);
    expect_block("cbc_dec_out", CT);
`else
    // Table of single blocks, each drained before the next.
    for (int v = 0; v < 6; v++) begin
      s0 = starts;
      send_block(vecs[v].din, vecs[v].md);
      expect_block($sformatf("vec%0d_out", v), vecs[v].dout);
      check($sformatf("vec%0d_core_data", v), seen_data, vecs[v].din);
      check($sformatf("vec%0d_core_mode", v), seen_mode, vecs[v].md);
      check($sformatf("vec%0d_starts", v), 128'(starts - s0), 1);
    end

    // Backpressure with a second block filled while the core is busy.
    toggle_en = 1'b1;
    s0 = starts;
    send_block(PT, 1'b0);
    wait_start(s0, "bp_first_start");
    send_block(128'h0, 1'b0);
    check("bp_second_waiting", starts - s0, 1);
    expect_block("bp_block_a", CT);
    expect_block("bp_block_b", KMIX);
    check("bp_starts", 128'(starts - s0), 2);
    check("bp_no_extra_words", 128'(got.size()), 0);
    toggle_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset after a partial block, then again while the core is working.
    mode = 1'b0;
    send_word(PT[127:96]);
    send_word(PT[95:64]);
    pulse_reset("rst_partial");
    s0 = starts;
    send_block(CT, 1'b1);
    wait_start(s0, "rst_wait_start");
    check("rst_wait_core_data", seen_data, CT);
    repeat (4) @(posedge clk);
    #1;
    pulse_reset("rst_wait");
    s0 = starts;
    send_block(PT, 1'b0);
    expect_block("after_reset", CT);
    check("after_reset_starts", 128'(starts - s0), 1);
`endif

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
